// File: rtl/csr_pkg.sv
// Shared CSR definitions for the machine-mode register file.
// Covers addresses, op encodings, bit positions and writable masks.
package csr_pkg;

    localparam logic [11:0] CSR_MSTATUS   = 12'h300;
    localparam logic [11:0] CSR_MIE       = 12'h304;
    localparam logic [11:0] CSR_MTVEC     = 12'h305;
    localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
    localparam logic [11:0] CSR_MEPC      = 12'h341;
    localparam logic [11:0] CSR_MCAUSE    = 12'h342;
    localparam logic [11:0] CSR_MIP       = 12'h344;
    localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
    localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
    localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
    localparam logic [11:0] CSR_MINSTRETH = 12'hB82;

    typedef enum logic [1:0] {
        CSR_OP_NONE  = 2'b00,
        CSR_OP_WRITE = 2'b01,
        CSR_OP_SET   = 2'b10,
        CSR_OP_CLEAR = 2'b11
    } csr_op_e;

    localparam int unsigned MSTATUS_MIE_BIT  = 3;
    localparam int unsigned MSTATUS_MPIE_BIT = 7;
    localparam int unsigned MIP_MTIP_BIT     = 7;
    localparam int unsigned MIP_MEIP_BIT     = 11;

    localparam logic [31:0] MSTATUS_WMASK  = 32'h0000_0088;
    localparam logic [31:0] MSTATUS_MPP_RO = 32'h0000_1800;
    localparam logic [31:0] MIE_WMASK      = 32'h0000_0880;
    localparam logic [31:0] MTVEC_WMASK    = 32'hFFFF_FFFC;
    localparam logic [31:0] MEPC_WMASK     = 32'hFFFF_FFFC;

    function automatic logic [31:0] csr_rmw(input logic [31:0] old_val,
                                            input logic [31:0] wdata,
                                            input csr_op_e     op);
        logic [31:0] res;
        case (op)
            CSR_OP_WRITE: res = wdata;
            CSR_OP_SET:   res = old_val | wdata;
            CSR_OP_CLEAR: res = old_val & ~wdata;
            default:      res = old_val;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/csr_counter64.sv
// 64-bit free-running counter with per-half CSR write access.
// A write to either half suppresses that cycle's increment.
module csr_counter64
    import csr_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        inc_i,
    input  logic        wr_lo_i,
    input  logic        wr_hi_i,
    input  logic [31:0] wdata_i,
    output logic [63:0] count_o
);

    logic [63:0] cnt_q;
    logic [63:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (wr_lo_i || wr_hi_i) begin
            if (wr_lo_i) cnt_d[31:0]  = wdata_i;
            if (wr_hi_i) cnt_d[63:32] = wdata_i;
        end else if (inc_i) begin
            cnt_d = cnt_q + 64'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

    assign count_o = cnt_q;

endmodule

// File: rtl/csr_file.sv
// Machine-mode CSR file: trap state, RMW writes at writeback, combinational reads.
// Define CSR_COUNTERS_EN to add mcycle/minstret (and their high halves).
module csr_file
    import csr_pkg::*;
#(
    parameter logic [31:0] MTVEC_RESET = 32'h0000_0000,
    parameter int unsigned XLEN        = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [11:0]     csr_raddr_in,
    output logic [XLEN-1:0] csr_rdata_out,
    input  logic [11:0]     csr_waddr_in,
    input  logic [XLEN-1:0] csr_wdata_in,
    input  logic [1:0]      csr_op_in,
    input  logic            csr_wr_en_in,
    input  logic            instr_retire_in,
    input  logic            trap_in,
    input  logic [XLEN-1:0] trap_cause_in,
    input  logic [XLEN-1:0] trap_pc_in,
    input  logic            mret_in,
    input  logic            ext_irq_in,
    input  logic            timer_irq_in,
    output logic [XLEN-1:0] trap_vector_out,
    output logic [XLEN-1:0] epc_out,
    output logic            irq_pending_out
);

    logic        mstatus_mie_q, mstatus_mie_d;
    logic        mstatus_mpie_q, mstatus_mpie_d;
    logic [31:0] mie_q, mie_d;
    logic [31:0] mtvec_q, mtvec_d;
    logic [31:0] mscratch_q, mscratch_d;
    logic [31:0] mepc_q, mepc_d;
    logic [31:0] mcause_q, mcause_d;

    logic [31:0] mstatus_view;
    logic [31:0] mip_view;
    logic [31:0] wr_old;
    logic [31:0] wr_val;
    logic        wr_fire;

`ifdef CSR_COUNTERS_EN
    logic [63:0] mcycle_w;
    logic [63:0] minstret_w;
`else
    logic        unused_retire;
    assign unused_retire = instr_retire_in;
`endif

    always_comb begin
        mstatus_view = MSTATUS_MPP_RO;
        mstatus_view[MSTATUS_MIE_BIT]  = mstatus_mie_q;
        mstatus_view[MSTATUS_MPIE_BIT] = mstatus_mpie_q;
        mip_view = '0;
        mip_view[MIP_MEIP_BIT] = ext_irq_in;
        mip_view[MIP_MTIP_BIT] = timer_irq_in;
    end

    function automatic logic [31:0] csr_mux(input logic [11:0] addr,
                                            input logic [31:0] mstatus_v,
                                            input logic [31:0] mip_v,
                                            input logic [31:0] mie_v,
                                            input logic [31:0] mtvec_v,
                                            input logic [31:0] mscratch_v,
                                            input logic [31:0] mepc_v,
                                            input logic [31:0] mcause_v,
                                            input logic [63:0] mcycle_v,
                                            input logic [63:0] minstret_v);
        logic [31:0] res;
        case (addr)
            CSR_MSTATUS:   res = mstatus_v;
            CSR_MIE:       res = mie_v;
            CSR_MTVEC:     res = mtvec_v;
            CSR_MSCRATCH:  res = mscratch_v;
            CSR_MEPC:      res = mepc_v;
            CSR_MCAUSE:    res = mcause_v;
            CSR_MIP:       res = mip_v;
`ifdef CSR_COUNTERS_EN
            CSR_MCYCLE:    res = mcycle_v[31:0];
            CSR_MCYCLEH:   res = mcycle_v[63:32];
            CSR_MINSTRET:  res = minstret_v[31:0];
            CSR_MINSTRETH: res = minstret_v[63:32];
`endif
            default:       res = '0;
        endcase
        return res;
    endfunction

    logic [63:0] cyc_view;
    logic [63:0] ret_view;
`ifdef CSR_COUNTERS_EN
    assign cyc_view = mcycle_w;
    assign ret_view = minstret_w;
`else
    assign cyc_view = '0;
    assign ret_view = '0;
`endif

    always_comb begin
        csr_rdata_out = csr_mux(csr_raddr_in, mstatus_view, mip_view, mie_q, mtvec_q,
                                mscratch_q, mepc_q, mcause_q, cyc_view, ret_view);
        wr_old        = csr_mux(csr_waddr_in, mstatus_view, mip_view, mie_q, mtvec_q,
                                mscratch_q, mepc_q, mcause_q, cyc_view, ret_view);
    end

    assign wr_fire = csr_wr_en_in && (csr_op_in != CSR_OP_NONE);
    assign wr_val  = csr_rmw(wr_old, csr_wdata_in, csr_op_e'(csr_op_in));

    always_comb begin
        mstatus_mie_d  = mstatus_mie_q;
        mstatus_mpie_d = mstatus_mpie_q;
        mie_d          = mie_q;
        mtvec_d        = mtvec_q;
        mscratch_d     = mscratch_q;
        mepc_d         = mepc_q;
        mcause_d       = mcause_q;
        if (wr_fire) begin
            case (csr_waddr_in)
                CSR_MSTATUS: begin
                    mstatus_mie_d  = wr_val[MSTATUS_MIE_BIT];
                    mstatus_mpie_d = wr_val[MSTATUS_MPIE_BIT];
                end
                CSR_MIE:      mie_d      = wr_val & MIE_WMASK;
                CSR_MTVEC:    mtvec_d    = wr_val & MTVEC_WMASK;
                CSR_MSCRATCH: mscratch_d = wr_val;
                CSR_MEPC:     mepc_d     = wr_val & MEPC_WMASK;
                CSR_MCAUSE:   mcause_d   = wr_val;
                default: ;
            endcase
        end
        // Trap/mret are applied last so they override any CSR write to the same state.
        if (trap_in) begin
            mepc_d         = trap_pc_in & MEPC_WMASK;
            mcause_d       = trap_cause_in;
            mstatus_mpie_d = mstatus_mie_q;
            mstatus_mie_d  = 1'b0;
        end else if (mret_in) begin
            mstatus_mie_d  = mstatus_mpie_q;
            mstatus_mpie_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mstatus_mie_q  <= 1'b0;
            mstatus_mpie_q <= 1'b0;
            mie_q          <= '0;
            mtvec_q        <= MTVEC_RESET & MTVEC_WMASK;
            mscratch_q     <= '0;
            mepc_q         <= '0;
            mcause_q       <= '0;
        end else begin
            mstatus_mie_q  <= mstatus_mie_d;
            mstatus_mpie_q <= mstatus_mpie_d;
            mie_q          <= mie_d;
            mtvec_q        <= mtvec_d;
            mscratch_q     <= mscratch_d;
            mepc_q         <= mepc_d;
            mcause_q       <= mcause_d;
        end
    end

`ifdef CSR_COUNTERS_EN
    csr_counter64 u_mcycle (
        .clk     (clk),
        .rst     (rst),
        .inc_i   (1'b1),
        .wr_lo_i (wr_fire && (csr_waddr_in == CSR_MCYCLE)),
        .wr_hi_i (wr_fire && (csr_waddr_in == CSR_MCYCLEH)),
        .wdata_i (wr_val),
        .count_o (mcycle_w)
    );

    csr_counter64 u_minstret (
        .clk     (clk),
        .rst     (rst),
        .inc_i   (instr_retire_in),
        .wr_lo_i (wr_fire && (csr_waddr_in == CSR_MINSTRET)),
        .wr_hi_i (wr_fire && (csr_waddr_in == CSR_MINSTRETH)),
        .wdata_i (wr_val),
        .count_o (minstret_w)
    );
`endif

    assign trap_vector_out = mtvec_q;
    assign epc_out         = mepc_q;
    assign irq_pending_out = mstatus_mie_q & (|(mie_q & mip_view));

endmodule

// File: tb/tb_csr_file.sv
// Directed bench for csr_file with a queue-based scoreboard.
// Counter checks follow CSR_COUNTERS_EN.
module tb_csr_file;

    localparam logic [11:0] A_MSTATUS   = 12'h300;
    localparam logic [11:0] A_MIE       = 12'h304;
    localparam logic [11:0] A_MTVEC     = 12'h305;
    localparam logic [11:0] A_MSCRATCH  = 12'h340;
    localparam logic [11:0] A_MEPC      = 12'h341;
    localparam logic [11:0] A_MCAUSE    = 12'h342;
    localparam logic [11:0] A_MIP       = 12'h344;
    localparam logic [11:0] A_MCYCLE    = 12'hB00;
    localparam logic [11:0] A_MINSTRET  = 12'hB02;
    localparam logic [11:0] A_MCYCLEH   = 12'hB80;
    localparam logic [11:0] A_MINSTRETH = 12'hB82;

    localparam logic [1:0] OP_W = 2'b01;
    localparam logic [1:0] OP_S = 2'b10;
    localparam logic [1:0] OP_C = 2'b11;

    localparam int K_RD   = 0;
    localparam int K_IRQ  = 1;
    localparam int K_TVEC = 2;
    localparam int K_EPC  = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic [11:0] csr_raddr_in;
    logic [31:0] csr_rdata_out;
    logic [11:0] csr_waddr_in;
    logic [31:0] csr_wdata_in;
    logic [1:0]  csr_op_in;
    logic        csr_wr_en_in;
    logic        instr_retire_in;
    logic        trap_in;
    logic [31:0] trap_cause_in;
    logic [31:0] trap_pc_in;
    logic        mret_in;
    logic        ext_irq_in;
    logic        timer_irq_in;
    logic [31:0] trap_vector_out;
    logic [31:0] epc_out;
    logic        irq_pending_out;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string       tag;
        int          kind;
        logic [11:0] addr;
        logic [31:0] exp;
    } exp_t;

    exp_t sb[$];

    csr_file #(.MTVEC_RESET(32'h0000_1003), .XLEN(32)) dut (
        .clk             (clk),
        .rst             (rst),
        .csr_raddr_in    (csr_raddr_in),
        .csr_rdata_out   (csr_rdata_out),
        .csr_waddr_in    (csr_waddr_in),
        .csr_wdata_in    (csr_wdata_in),
        .csr_op_in       (csr_op_in),
        .csr_wr_en_in    (csr_wr_en_in),
        .instr_retire_in (instr_retire_in),
        .trap_in         (trap_in),
        .trap_cause_in   (trap_cause_in),
        .trap_pc_in      (trap_pc_in),
        .mret_in         (mret_in),
        .ext_irq_in      (ext_irq_in),
        .timer_irq_in    (timer_irq_in),
        .trap_vector_out (trap_vector_out),
        .epc_out         (epc_out),
        .irq_pending_out (irq_pending_out)
    );

    always #10 clk = ~clk;

    task automatic expect_v(input string tag, input int kind,
                            input logic [11:0] addr, input logic [31:0] exp);
        exp_t e;
        e.tag  = tag;
        e.kind = kind;
        e.addr = addr;
        e.exp  = exp;
        sb.push_back(e);
    endtask

    // Pops every queued expectation and compares, 1 ns apart, mid-cycle.
    task automatic drain();
        exp_t        e;
        logic [31:0] obs;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            csr_raddr_in = e.addr;
            #1;
            case (e.kind)
                K_RD:    obs = csr_rdata_out;
                K_IRQ:   obs = {31'b0, irq_pending_out};
                K_TVEC:  obs = trap_vector_out;
                default: obs = epc_out;
            endcase
            checks++;
            assert (obs === e.exp) else begin
                errors++;
                $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.exp);
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic csr_wr(input logic [11:0] addr, input logic [1:0] op,
                          input logic [31:0] data);
        csr_waddr_in = addr;
        csr_op_in    = op;
        csr_wdata_in = data;
        csr_wr_en_in = 1'b1;
        step();
        csr_wr_en_in = 1'b0;
        csr_op_in    = 2'b00;
    endtask

    initial begin
        rst = 1'b1;
        csr_raddr_in = '0;
        csr_waddr_in = '0;
        csr_wdata_in = '0;
        csr_op_in = 2'b00;
        csr_wr_en_in = 1'b0;
        instr_retire_in = 1'b0;
        trap_in = 1'b0;
        trap_cause_in = '0;
        trap_pc_in = '0;
        mret_in = 1'b0;
        ext_irq_in = 1'b0;
        timer_irq_in = 1'b0;
        step();
        step();

        expect_v("rst_mtvec", K_RD, A_MTVEC, 32'h0000_1000);
        expect_v("rst_tvec_out", K_TVEC, A_MTVEC, 32'h0000_1000);
        expect_v("rst_mstatus", K_RD, A_MSTATUS, 32'h0000_1800);
        expect_v("rst_mepc", K_RD, A_MEPC, 32'h0);
        expect_v("rst_mcause", K_RD, A_MCAUSE, 32'h0);
        expect_v("rst_mie", K_RD, A_MIE, 32'h0);
        expect_v("rst_irq", K_IRQ, A_MIE, 32'h0);
        expect_v("rst_epc_out", K_EPC, A_MIE, 32'h0);
        drain();
        rst = 1'b0;

        csr_wr(A_MIE, OP_S, 32'h0000_0888);
        expect_v("mie_set", K_RD, A_MIE, 32'h0000_0880);
        drain();
        csr_wr(A_MIE, OP_C, 32'h0000_0080);
        expect_v("mie_clear", K_RD, A_MIE, 32'h0000_0800);
        drain();

        csr_wr(A_MSTATUS, OP_W, 32'hFFFF_FFFF);
        expect_v("mstatus_mask", K_RD, A_MSTATUS, 32'h0000_1888);
        drain();
        csr_wr(A_MSTATUS, OP_C, 32'h0000_0080);
        expect_v("mstatus_clr_mpie", K_RD, A_MSTATUS, 32'h0000_1808);
        drain();

        trap_in = 1'b1; trap_cause_in = 32'h8000_000B; trap_pc_in = 32'h0000_0102;
        step();
        trap_in = 1'b0;
        expect_v("trap_mepc", K_RD, A_MEPC, 32'h0000_0100);
        expect_v("trap_epc_out", K_EPC, A_MEPC, 32'h0000_0100);
        expect_v("trap_mcause", K_RD, A_MCAUSE, 32'h8000_000B);
        expect_v("trap_mstatus", K_RD, A_MSTATUS, 32'h0000_1880);
        drain();

        mret_in = 1'b1;
        step();
        mret_in = 1'b0;
        expect_v("mret_mstatus", K_RD, A_MSTATUS, 32'h0000_1888);
        drain();

        trap_in = 1'b1; trap_cause_in = 32'h0000_0002; trap_pc_in = 32'h0000_0204;
        csr_wr(A_MEPC, OP_W, 32'hDEAD_BEEC);
        trap_in = 1'b0;
        expect_v("trap_beats_mepc_wr", K_RD, A_MEPC, 32'h0000_0204);
        expect_v("trap2_mcause", K_RD, A_MCAUSE, 32'h0000_0002);
        expect_v("trap2_mstatus", K_RD, A_MSTATUS, 32'h0000_1880);
        drain();

        trap_in = 1'b1; trap_cause_in = 32'h0000_0003; trap_pc_in = 32'h0000_0300;
        csr_wr(A_MSCRATCH, OP_W, 32'h1234_5678);
        trap_in = 1'b0;
        expect_v("trap_with_mscratch_wr", K_RD, A_MSCRATCH, 32'h1234_5678);
        expect_v("trap3_mepc", K_RD, A_MEPC, 32'h0000_0300);
        expect_v("trap3_mstatus", K_RD, A_MSTATUS, 32'h0000_1800);
        drain();

        mret_in = 1'b1;
        csr_wr(A_MSTATUS, OP_W, 32'h0000_0000);
        mret_in = 1'b0;
        expect_v("mret_beats_mstatus_wr", K_RD, A_MSTATUS, 32'h0000_1880);
        drain();

        csr_wr(A_MEPC, OP_W, 32'hDEAD_BEEF);
        expect_v("mepc_wr_mask", K_RD, A_MEPC, 32'hDEAD_BEEC);
        expect_v("mepc_wr_epc_out", K_EPC, A_MEPC, 32'hDEAD_BEEC);
        drain();

        csr_wr(A_MTVEC, OP_W, 32'h8000_0107);
        expect_v("mtvec_wr", K_RD, A_MTVEC, 32'h8000_0104);
        expect_v("mtvec_tvec_out", K_TVEC, A_MTVEC, 32'h8000_0104);
        drain();

        csr_wr(A_MSTATUS, OP_S, 32'h0000_0008);
        expect_v("irq_idle", K_IRQ, A_MSTATUS, 32'h0);
        drain();
        ext_irq_in = 1'b1;
        expect_v("irq_ext_same_cycle", K_IRQ, A_MIP, 32'h1);
        expect_v("mip_meip", K_RD, A_MIP, 32'h0000_0800);
        drain();
        csr_waddr_in = A_MSTATUS; csr_op_in = OP_C; csr_wdata_in = 32'h8; csr_wr_en_in = 1'b1;
        expect_v("irq_before_clr_edge", K_IRQ, A_MSTATUS, 32'h1);
        drain();
        step();
        csr_wr_en_in = 1'b0; csr_op_in = 2'b00;
        expect_v("irq_after_mie_clr", K_IRQ, A_MSTATUS, 32'h0);
        expect_v("mstatus_after_clr", K_RD, A_MSTATUS, 32'h0000_1880);
        drain();

        ext_irq_in = 1'b0;
        timer_irq_in = 1'b1;
        expect_v("mip_mtip", K_RD, A_MIP, 32'h0000_0080);
        drain();
        csr_wr(A_MIE, OP_S, 32'h0000_0080);
        csr_wr(A_MSTATUS, OP_S, 32'h0000_0008);
        expect_v("irq_timer", K_IRQ, A_MIE, 32'h1);
        drain();
        timer_irq_in = 1'b0;
        expect_v("irq_timer_drop", K_IRQ, A_MIE, 32'h0);
        drain();

        csr_wr(12'h7C0, OP_W, 32'hFFFF_FFFF);
        expect_v("unimpl_read", K_RD, 12'h7C0, 32'h0);
        drain();

`ifdef CSR_COUNTERS_EN
        csr_wr(A_MCYCLE, OP_W, 32'hFFFF_FFFF);
        csr_wr(A_MCYCLEH, OP_W, 32'hFFFF_FFFF);
        expect_v("mcycle_max_lo", K_RD, A_MCYCLE, 32'hFFFF_FFFF);
        expect_v("mcycle_max_hi", K_RD, A_MCYCLEH, 32'hFFFF_FFFF);
        drain();
        step();
        expect_v("mcycle_wrap_lo", K_RD, A_MCYCLE, 32'h0);
        expect_v("mcycle_wrap_hi", K_RD, A_MCYCLEH, 32'h0);
        drain();
        csr_wr(A_MCYCLE, OP_W, 32'h0000_0005);
        expect_v("mcycle_wr5", K_RD, A_MCYCLE, 32'h5);
        drain();
        step();
        expect_v("mcycle_inc6", K_RD, A_MCYCLE, 32'h6);
        expect_v("mcycleh_zero", K_RD, A_MCYCLEH, 32'h0);
        drain();

        instr_retire_in = 1'b1;
        csr_wr(A_MINSTRET, OP_W, 32'h0);
        expect_v("minstret_wr_wins", K_RD, A_MINSTRET, 32'h0);
        drain();
        step();
        step();
        step();
        instr_retire_in = 1'b0;
        expect_v("minstret_count3", K_RD, A_MINSTRET, 32'h3);
        expect_v("minstreth_zero", K_RD, A_MINSTRETH, 32'h0);
        drain();
        csr_wr(A_MINSTRET, OP_S, 32'h0000_0010);
        expect_v("minstret_set", K_RD, A_MINSTRET, 32'h13);
        drain();
`else
        csr_wr(A_MCYCLE, OP_W, 32'h0000_0005);
        step();
        expect_v("nocnt_mcycle", K_RD, A_MCYCLE, 32'h0);
        expect_v("nocnt_mcycleh", K_RD, A_MCYCLEH, 32'h0);
        expect_v("nocnt_minstret", K_RD, A_MINSTRET, 32'h0);
        expect_v("nocnt_minstreth", K_RD, A_MINSTRETH, 32'h0);
        drain();
`endif

        trap_in = 1'b1; trap_cause_in = 32'h0000_0007; trap_pc_in = 32'h0000_0444;
        rst = 1'b1;
        step();
        rst = 1'b0;
        trap_in = 1'b0;
        expect_v("rst_over_trap_mepc", K_RD, A_MEPC, 32'h0);
        expect_v("rst_over_trap_mcause", K_RD, A_MCAUSE, 32'h0);
        expect_v("rst2_mstatus", K_RD, A_MSTATUS, 32'h0000_1800);
        expect_v("rst2_mtvec", K_RD, A_MTVEC, 32'h0000_1000);
        expect_v("rst2_mscratch", K_RD, A_MSCRATCH, 32'h0);
`ifdef CSR_COUNTERS_EN
        expect_v("rst2_mcycle", K_RD, A_MCYCLE, 32'h0);
        expect_v("rst2_minstret", K_RD, A_MINSTRET, 32'h0);
`endif
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
